vid_stream_out: RTL

- Video output stage directly downstream of the 256-in/16-out prefetch FIFO.
- Runs in the FIFO read clock domain and generates raster timing (hs/vs/de).
- Pops one 16-bit pixel per active cycle from the FIFO's first-word-fall-through read port and drives a registered pixel bus to the display encoder.
- Requests frame refills from the upstream DDR reader and counts pixel underflows.

---
 rtl/vid_stream_out.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/vid_stream_out.sv
// Raster timing generator that pops one pixel per active cycle from a FWFT FIFO; outputs registered, 1 cycle after counters.
// No backpressure: the raster never stalls, an empty FIFO during active video yields FILL_DATA and is counted as underflow.
module vid_stream_out #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    H_ACTIVE   = 1920,
    parameter int                    H_FP       = 88,
    parameter int                    H_SYNC     = 44,
    parameter int                    H_BP       = 148,
    parameter int                    V_ACTIVE   = 1080,
    parameter int                    V_FP       = 4,
    parameter int                    V_SYNC     = 5,
    parameter int                    V_BP       = 36,
    parameter bit                    HS_POL     = 1'b1,
    parameter bit                    VS_POL     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] FILL_DATA  = '0
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    input  logic                  clr_status,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_vld,
    output logic                  fifo_rd_en,
    output logic                  frame_req,
    output logic                  vout_hs,
    output logic                  vout_vs,
    output logic                  vout_de,
    output logic [DATA_WIDTH-1:0] vout_data,
    output logic                  underflow,
    output logic [15:0]           underflow_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [HW-1:0]           h_cnt_q, h_cnt_d;
    logic [VW-1:0]           v_cnt_q, v_cnt_d;
    logic                    frame_req_q, frame_req_d;
    logic                    hs_q, hs_d;
    logic                    vs_q, vs_d;
    logic                    de_q;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    underflow_q, underflow_d;
    logic [15:0]             ucnt_q, ucnt_d;

    logic run;
    logic h_act;
    logic v_act;
    logic de_int;
    logic uf_evt;
    logic h_last;
    logic v_last;

    assign run    = (state_q == S_RUN);
    assign h_act  = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END);
    assign v_act  = (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
    assign de_int = h_act && v_act && run;
    assign uf_evt = de_int && !fifo_rd_vld;
    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);

    // FWFT port: the pop and the data capture happen in the same cycle.
    assign fifo_rd_en = de_int;

    always_comb begin
        state_d     = state_q;
        h_cnt_d     = '0;
        v_cnt_d     = '0;
        frame_req_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d     = S_WAIT;
                    frame_req_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (fifo_rd_vld) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (h_last) begin
                    h_cnt_d = '0;
                    if (v_last) begin
                        v_cnt_d = '0;
                        // A stop request only takes effect on a frame boundary.
                        if (!enable) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        v_cnt_d = v_cnt_q + 1'b1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 1'b1;
                    v_cnt_d = v_cnt_q;
                end
                frame_req_d = (h_cnt_q == '0) && (v_cnt_q == V_ACT_END);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        hs_d = (run && (h_cnt_q < H_SYNC_END)) ? HS_POL : ~HS_POL;
        vs_d = (run && (v_cnt_q < V_SYNC_END)) ? VS_POL : ~VS_POL;
        if (!de_int) begin
            data_d = '0;
        end else if (fifo_rd_vld) begin
            data_d = fifo_rd_data;
        end else begin
            data_d = FILL_DATA;
        end
    end

    // A same-cycle underflow beats the clear so no lost pixel goes unreported.
    always_comb begin
        underflow_d = underflow_q;
        ucnt_d      = ucnt_q;
        if (uf_evt) begin
            underflow_d = 1'b1;
            if (clr_status) begin
                ucnt_d = 16'd1;
            end else if (ucnt_q != 16'hFFFF) begin
                ucnt_d = ucnt_q + 16'd1;
            end
        end else if (clr_status) begin
            underflow_d = 1'b0;
            ucnt_d      = 16'd0;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q     <= S_IDLE;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_req_q <= 1'b0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            de_q        <= 1'b0;
            data_q      <= '0;
            underflow_q <= 1'b0;
            ucnt_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_req_q <= frame_req_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_int;
            data_q      <= data_d;
            underflow_q <= underflow_d;
            ucnt_q      <= ucnt_d;
        end
    end

    assign frame_req     = frame_req_q;
    assign vout_hs       = hs_q;
    assign vout_vs       = vs_q;
    assign vout_de       = de_q;
    assign vout_data     = data_q;
    assign underflow     = underflow_q;
    assign underflow_cnt = ucnt_q;

endmodule
